mult_div_sequencer: RTL

- Multi-cycle multiply/divide unit with its own HI/LO registers. It takes MULT/MULTU/DIV/DIVU off the combinational ALU path.
- Sequences a 32-step shift-add multiply or restoring divide, and raises busy so the core can stall MFHI/MFLO and new mult/div issue.
- Sits beside the ALU. It is driven by the decoded ALU_control and fed by the same two ALU operand buses.

---
 rtl/mult_div_sequencer_pkg.sv | 26 ++
 rtl/mult_div_sequencer_if.sv | 32 +++
 rtl/mult_div_sequencer_cond_negate.sv | 15 +
 rtl/mult_div_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// md_pkg : shared constants, op encodings and FSM states for mult_div_sequencer
// Revision: 1.0
// ============================================================================
package md_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/mult_div_sequencer_if.sv
`default_nettype none
// ============================================================================
// mult_div_sequencer_if : core-side request/result bundle for the mult/div unit
// Revision: 1.0
// ============================================================================
interface mult_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             MD_start;
  logic [1:0]       MD_op;
  logic [WIDTH-1:0] MD_IN_1;
  logic [WIDTH-1:0] MD_IN_2;
  logic             HI_write;
  logic             LO_write;
  logic [WIDTH-1:0] HILO_wdata;
  logic             MD_busy;
  logic             MD_done;
  logic             MD_div_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output MD_start, MD_op, MD_IN_1, MD_IN_2, HI_write, LO_write, HILO_wdata,
    input  MD_busy, MD_done, MD_div_zero, HI, LO
  );

  modport slave (
    input  MD_start, MD_op, MD_IN_1, MD_IN_2, HI_write, LO_write, HILO_wdata,
    output MD_busy, MD_done, MD_div_zero, HI, LO
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_sequencer_cond_negate.sv
`default_nettype none
// ============================================================================
// md_cond_negate : combinational two's-complement negate when i_neg is set
// Revision: 1.0
// ============================================================================
module md_cond_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_y
);
  assign o_y = i_neg ? (~i_a + W'(1)) : i_a;
endmodule
`default_nettype wire

// File: rtl/mult_div_sequencer.sv
`default_nettype none
// ============================================================================
// mult_div_sequencer : 32-step shift-add multiply / restoring divide with HI/LO
// Revision: 1.0
// ============================================================================
module mult_div_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = md_pkg::WIDTH,
  parameter int CNT_W = md_pkg::CNT_W
) (
  input logic                 CLK,
  input logic                 RESET,
  mult_div_sequencer_if.slave bus
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  md_op_e           w_op;
  logic             w_signed_op;
  logic             w_div_op;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH:0]   w_mul_add;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_op        = md_op_e'(bus.MD_op);
  assign w_signed_op = (w_op == MD_MULT) || (w_op == MD_DIV);
  assign w_div_op    = (w_op == MD_DIVU) || (w_op == MD_DIV);

  md_cond_negate #(.W(WIDTH)) u_mag1 (
    .i_neg (w_signed_op & bus.MD_IN_1[WIDTH-1]),
    .i_a   (bus.MD_IN_1),
    .o_y   (w_mag1)
  );

  md_cond_negate #(.W(WIDTH)) u_mag2 (
    .i_neg (w_signed_op & bus.MD_IN_2[WIDTH-1]),
    .i_a   (bus.MD_IN_2),
    .o_y   (w_mag2)
  );

  // The low half of the 64-bit negate is also the negated quotient for divides.
  md_cond_negate #(.W(2*WIDTH)) u_prod_fix (
    .i_neg (neg_res_q),
    .i_a   ({acc_q[WIDTH-1:0], q_q}),
    .o_y   (w_prod_fix)
  );

  md_cond_negate #(.W(WIDTH)) u_rem_fix (
    .i_neg (neg_rem_q),
    .i_a   (acc_q[WIDTH-1:0]),
    .o_y   (w_rem_fix)
  );

  assign w_mul_add   = q_q[0] ? {1'b0, a_q} : '0;
  assign w_mul_sum   = acc_q + w_mul_add;
  assign w_div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, a_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.MD_start) begin
          state_d   = ST_CALC;
          cnt_d     = '0;
          acc_d     = '0;
          a_d       = w_mag2;
          q_d       = w_mag1;
          is_div_d  = w_div_op;
          neg_res_d = w_signed_op & (bus.MD_IN_1[WIDTH-1] ^ bus.MD_IN_2[WIDTH-1]);
          neg_rem_d = w_signed_op & w_div_op & bus.MD_IN_1[WIDTH-1];
          dz_d      = w_div_op & (bus.MD_IN_2 == '0);
        end else begin
          state_d = ST_IDLE;
          if (bus.HI_write) hi_d = bus.HILO_wdata;
          if (bus.LO_write) lo_d = bus.HILO_wdata;
        end
      end
      ST_CALC: begin
        if (is_div_q) begin
          if (!w_div_trial[WIDTH]) begin
            acc_d = w_div_trial;
            q_d   = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = w_div_shift;
            q_d   = {q_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {1'b0, w_mul_sum[WIDTH:1]};
          q_d   = {w_mul_sum[0], q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        // A zero divisor never fails the trial subtract, so the remainder
        // already equals the original dividend; only LO needs forcing.
        if (is_div_q) begin
          lo_d = dz_q ? '1 : w_prod_fix[WIDTH-1:0];
          hi_d = w_rem_fix;
        end else begin
          {hi_d, lo_d} = w_prod_fix;
        end
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d     = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d     = (state_d == ST_DONE);
    div_zero_d = (state_d == ST_DONE) && dz_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      a_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      a_q        <= a_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.MD_busy     = busy_q;
  assign bus.MD_done     = done_q;
  assign bus.MD_div_zero = div_zero_q;
  assign bus.HI          = hi_q;
  assign bus.LO          = lo_q;

endmodule
`default_nettype wire
